// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch stage: owns the fetch PC, keeps one memory request in flight and
// queues returned words with their PCs for decode. Define FETCH_STATS_EN to add the
// stall/redirect/dropped-response counters.
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] redirects,
  output logic [31:0] dropped_rsp
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_t;

  state_t        state_reg, state_next;
  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [31:0]   pend_pc_reg;
  logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [31:0]   last_instr_reg, last_pc_reg;
  logic [31:0]   data_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  logic full, issue, push, pop;

  assign full = (count_reg == FULL_CNT);

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    issue         = 1'b0;
    push          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!redirect && !full) begin
          issue      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          state_next = IDLE;
          push       = !redirect;
        end else if (redirect) begin
          state_next = DROP;
        end
      end
      DROP: begin
        if (imem_rsp_valid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (redirect) begin
      fetch_pc_next = redirect_pc;
    end else if (issue) begin
      fetch_pc_next = fetch_pc_reg + 32'd4;
    end
  end

  // The state register idles in IDLE while reset is held, so gate the strobe explicitly.
  assign imem_req  = issue & rst_n;
  assign imem_addr = fetch_pc_reg;

  assign instr_valid = (count_reg != '0);
  assign pop         = instr_valid && instr_ready && !redirect;

  // Head comes straight from storage; the last shown entry is held once the queue drains.
  assign instruction = instr_valid ? data_mem[rd_ptr_reg] : last_instr_reg;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr_reg]   : last_pc_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      fetch_pc_reg   <= RESET_PC;
      pend_pc_reg    <= RESET_PC;
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
      last_instr_reg <= '0;
      last_pc_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      if (issue) begin
        pend_pc_reg <= fetch_pc_reg;
      end
      if (redirect) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + PW'(1);
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + PW'(1);
        end
        case ({push, pop})
          2'b10:   count_reg <= count_reg + CW'(1);
          2'b01:   count_reg <= count_reg - CW'(1);
          default: count_reg <= count_reg;
        endcase
      end
      if (instr_valid) begin
        last_instr_reg <= data_mem[rd_ptr_reg];
        last_pc_reg    <= pc_mem[rd_ptr_reg];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_reg] <= imem_rsp_data;
      pc_mem[wr_ptr_reg]   <= pend_pc_reg;
    end
  end

`ifdef FETCH_STATS_EN
  logic stall_hit, drop_hit;

  assign stall_hit = (state_reg == IDLE) && full && !redirect;
  assign drop_hit  = imem_rsp_valid &&
                     ((state_reg == DROP) || ((state_reg == WAIT) && redirect));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      redirects    <= '0;
      dropped_rsp  <= '0;
    end else begin
      if (stall_hit && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (redirect && (redirects != '1)) begin
        redirects <= redirects + 32'd1;
      end
      if (drop_hit && (dropped_rsp != '1)) begin
        dropped_rsp <= dropped_rsp + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: a cycle table for streaming fetch plus
// hand-written sequences for backpressure, redirects and mid-flight reset.
module tb_fetch_prefetch_queue;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_ready;
`ifdef FETCH_STATS_EN
  logic [31:0] stall_cycles, redirects, dropped_rsp;
`endif

  fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
`ifdef FETCH_STATS_EN
    ,
    .stall_cycles   (stall_cycles),
    .redirects      (redirects),
    .dropped_rsp    (dropped_rsp)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [31:0] rpc;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl [8];

  int n_vec  = 0;
  int n_miss = 0;

  // instruction memory model: word = addr ^ DEAD0000, fixed latency per request
  int          mem_lat;
  int          mem_cnt;
  logic        mem_busy;
  logic [31:0] mem_addr;

  logic [31:0] req_q[$];
  logic [31:0] pop_pc_q[$];
  logic [31:0] pop_in_q[$];

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;

  logic [31:0] exp2 [6];
  logic        found;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic rd, input logic [31:0] rpc);
    redirect       = rd;
    redirect_pc    = rpc;
    imem_rsp_valid = 1'b0;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_addr ^ 32'hDEAD_0000;
        mem_busy       = 1'b0;
      end
    end
    #1;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = instr_valid;
    s_pc    = instr_pc;
    s_instr = instruction;
    if (imem_req) begin
      req_q.push_back(imem_addr);
      mem_busy = 1'b1;
      mem_addr = imem_addr;
      mem_cnt  = mem_lat;
    end
    if (instr_valid && instr_ready && !rd) begin
      pop_pc_q.push_back(instr_pc);
      pop_in_q.push_back(instruction);
    end
    @(posedge clk);
    @(negedge clk);
    redirect = 1'b0;
  endtask

  task automatic clear_model();
    mem_busy       = 1'b0;
    mem_cnt        = 0;
    imem_rsp_valid = 1'b0;
    redirect       = 1'b0;
    req_q.delete();
    pop_pc_q.delete();
    pop_in_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_model();
    @(negedge clk);
    #1;
    chk("reset imem_req", 32'(imem_req), 32'h0);
    chk("reset imem_addr", imem_addr, 32'h0);
    chk("reset instr_valid", 32'(instr_valid), 32'h0);
    chk("reset instruction", instruction, 32'h0);
    chk("reset instr_pc", instr_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef FETCH_STATS_EN
  task automatic chk_stats(input string tag, input logic [31:0] st, input logic [31:0] rd,
                           input logic [31:0] dr);
    chk({tag, " stall_cycles"}, stall_cycles, st);
    chk({tag, " redirects"}, redirects, rd);
    chk({tag, " dropped_rsp"}, dropped_rsp, dr);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    mem_lat        = 1;
    mem_busy       = 1'b0;
    mem_cnt        = 0;
    mem_addr       = 32'h0;

    //            rd    rpc    rdy   req   addr   valid  pc     instr
    tbl[0] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    tbl[1] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
    tbl[2] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b1, 32'h0, 32'hDEAD_0000};
    tbl[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'hDEAD_0000};
    tbl[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 1'b1, 32'h4, 32'hDEAD_0004};
    tbl[5] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h4, 32'hDEAD_0004};
    tbl[6] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'hC, 1'b1, 32'h8, 32'hDEAD_0008};
    tbl[7] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h8, 32'hDEAD_0008};

    exp2 = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};

    // streaming fetch, 1-cycle memory, decode always ready
    do_reset();
    mem_lat = 1;
    for (int i = 0; i < 8; i++) begin
      instr_ready = tbl[i].ready;
      step(tbl[i].rd, tbl[i].rpc);
      chk($sformatf("s1[%0d] imem_req", i), 32'(s_req), 32'(tbl[i].e_req));
      if (tbl[i].e_req) chk($sformatf("s1[%0d] imem_addr", i), s_addr, tbl[i].e_addr);
      chk($sformatf("s1[%0d] instr_valid", i), 32'(s_valid), 32'(tbl[i].e_valid));
      chk($sformatf("s1[%0d] instr_pc", i), s_pc, tbl[i].e_pc);
      chk($sformatf("s1[%0d] instruction", i), s_instr, tbl[i].e_instr);
    end

    // backpressure: queue fills after four requests, then resumes at 0x10
    do_reset();
    instr_ready = 1'b0;
    for (int i = 0; i < 14; i++) step(1'b0, 32'h0);
    chk("s2 req count while full", req_q.size(), 32'd4);
    chk("s2 last req addr", req_q[3], 32'hC);
    chk("s2 req held low", 32'(s_req), 32'h0);
    chk("s2 head valid", 32'(s_valid), 32'h1);
    chk("s2 head pc", s_pc, 32'h0);
    instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("s2 req[%0d]", i), req_q[i], exp2[i]);
      chk($sformatf("s2 pop pc[%0d]", i), pop_pc_q[i], exp2[i]);
    end
    chk("s2 pop instr[3]", pop_in_q[3], 32'hDEAD_000C);
`ifdef FETCH_STATS_EN
    chk_stats("s2", 32'd7, 32'd0, 32'd0);
`endif

    // redirect while waiting on addr 8 with a 2-cycle memory
    do_reset();
    instr_ready = 1'b1;
    mem_lat     = 2;
    found       = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1'b0, 32'h0);
      if (req_q.size() >= 3) found = 1'b1;
    end
    chk("s3 reached req 8", 32'(found), 32'h1);
    chk("s3 req[2]", req_q[2], 32'h8);
    step(1'b1, 32'h40);
    step(1'b0, 32'h0);
    chk("s3 valid after redirect", 32'(s_valid), 32'h0);
    for (int i = 0; i < 9; i++) step(1'b0, 32'h0);
    chk("s3 req[3]", req_q[3], 32'h40);
    chk("s3 pop count", pop_pc_q.size(), 32'd4);
    chk("s3 pop pc[2]", pop_pc_q[2], 32'h40);
    chk("s3 pop instr[2]", pop_in_q[2], 32'hDEAD_0040);
    chk("s3 pop pc[3]", pop_pc_q[3], 32'h44);
`ifdef FETCH_STATS_EN
    chk_stats("s3", 32'd0, 32'd1, 32'd1);
`endif

    // redirect coinciding with a response, then a second redirect while in DROP
    do_reset();
    instr_ready = 1'b1;
    mem_lat     = 1;
    step(1'b0, 32'h0);
    step(1'b1, 32'h20);
    mem_lat = 3;
    step(1'b0, 32'h0);
    step(1'b1, 32'h60);
    step(1'b1, 32'h80);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0);
    chk("s4 req[1]", req_q[1], 32'h20);
    chk("s4 req[2]", req_q[2], 32'h80);
    chk("s4 pop count", pop_pc_q.size(), 32'd1);
    chk("s4 first pop pc", pop_pc_q[0], 32'h80);
    chk("s4 first pop instr", pop_in_q[0], 32'hDEAD_0080);
`ifdef FETCH_STATS_EN
    chk_stats("s4", 32'd0, 32'd3, 32'd2);
`endif

    // asynchronous reset mid-WAIT with three entries queued
    do_reset();
    instr_ready = 1'b0;
    mem_lat     = 1;
    for (int i = 0; i < 7; i++) step(1'b0, 32'h0);
    #1;
    chk("s5 valid before reset", 32'(instr_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5 valid in reset", 32'(instr_valid), 32'h0);
    chk("s5 req in reset", 32'(imem_req), 32'h0);
    chk("s5 pc in reset", instr_pc, 32'h0);
    chk("s5 instr in reset", instruction, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    step(1'b0, 32'h0);
    chk("s5 first req after reset", req_q.size(), 32'd1);
    chk("s5 first addr after reset", req_q[0], 32'h0);
    chk("s5 valid after reset", 32'(s_valid), 32'h0);

    // flush a full queue; the same-cycle pop must be ignored
    do_reset();
    instr_ready = 1'b0;
    mem_lat     = 1;
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0);
    instr_ready = 1'b1;
    step(1'b1, 32'h100);
    step(1'b0, 32'h0);
    chk("s7 valid after flush", 32'(s_valid), 32'h0);
    chk("s7 req after flush", 32'(s_req), 32'h1);
    chk("s7 addr after flush", s_addr, 32'h100);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0);
    chk("s7 pop count", pop_pc_q.size(), 32'd1);
    chk("s7 first pop pc", pop_pc_q[0], 32'h100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
